arb16_16: RTL and testbench

ARB16_16 -- requirements
Module: arb16_16

---
 rtl/arb16_16.sv | 74 +++++++
 tb/tb_arb16_16.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/arb16_16.sv
// Round-robin 16:1 arbiter that captures one 16-bit word per grant; 1-cycle grant-to-dout_valid latency.
// While dout_valid is high and dout_ready is low, everything holds and no grant is issued.
module arb16_16 (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  req,
  input  logic [255:0] din,
  output logic [15:0]  gnt,
  output logic [3:0]   sel,
  output logic [15:0]  dout,
  output logic         dout_valid,
  input  logic         dout_ready
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [3:0]  ptr;
  logic        arb;
  logic        found;
  logic [3:0]  win;
  logic [3:0]  idx;
  logic [15:0] win_word;

  // A cycle arbitrates when the output slot is empty or being emptied right now.
  assign arb = !reset && ((state == IDLE) || dout_ready);

  // First requester at or above ptr, wrapping 15 -> 0.
  always_comb begin
    found = 1'b0;
    win   = 4'd0;
    idx   = 4'd0;
    for (int k = 0; k < 16; k++) begin
      idx = ptr + 4'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_word = din[{win, 4'b0000} +: 16];
  assign gnt      = (arb && found) ? (16'h0001 << win) : 16'h0000;

  always_comb begin
    state_nxt = state;
    if (arb) begin
      state_nxt = found ? BUSY : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= 16'h0000;
      sel  <= 4'd0;
      ptr  <= 4'd0;
    end else if (arb && found) begin
      dout <= win_word;
      sel  <= win;
      ptr  <= win + 4'd1;
    end
  end

  assign dout_valid = (state == BUSY);

endmodule

// File: tb/tb_arb16_16.sv
// Directed bench for arb16_16: reset, first grant, fairness, wrap, backpressure, drain, mid-transfer reset.
module tb_arb16_16;

  logic         clk;
  logic         reset;
  logic [15:0]  req;
  logic [255:0] din;
  logic [15:0]  gnt;
  logic [3:0]   sel;
  logic [15:0]  dout;
  logic         dout_valid;
  logic         dout_ready;

  int n_total;
  int n_pass;

  arb16_16 dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .din        (din),
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setw(input int i, input logic [15:0] v);
    din[16*i +: 16] = v;
  endtask

  task automatic chk_out(input string tag, input logic [15:0] d, input logic [3:0] s, input logic v);
    chk({tag, ".dout"}, 32'(dout), 32'(d));
    chk({tag, ".sel"}, 32'(sel), 32'(s));
    chk({tag, ".valid"}, 32'(dout_valid), 32'(v));
  endtask

  logic [15:0] fair_gnt [4];
  logic [15:0] fair_word [4];
  logic [3:0]  fair_sel [4];

  initial begin
    n_total    = 0;
    n_pass     = 0;
    reset      = 1'b1;
    req        = 16'h0000;
    din        = '0;
    dout_ready = 1'b0;

    // Reset state; gnt stays 0 even with requests and ready present.
    tick();
    req        = 16'hFFFF;
    dout_ready = 1'b1;
    #1;
    chk("rst.gnt", 32'(gnt), 32'h0);
    tick();
    chk_out("rst", 16'h0000, 4'd0, 1'b0);

    // First grant.
    reset = 1'b0;
    req   = 16'h0001;
    setw(0, 16'hA5A5);
    setw(1, 16'h1111);
    #1;
    chk("g0.gnt", 32'(gnt), 32'h0001);
    tick();
    chk_out("g0", 16'hA5A5, 4'd0, 1'b1);

    // ptr is now 1, so requester 1 beats requester 0.
    req = 16'h0003;
    #1;
    chk("ptr1.gnt", 32'(gnt), 32'h0002);
    tick();
    chk_out("ptr1", 16'h1111, 4'd1, 1'b1);

    // Grant 15 to bring ptr back to 0.
    req = 16'h8000;
    setw(15, 16'hF00F);
    #1;
    chk("g15.gnt", 32'(gnt), 32'h8000);
    tick();
    chk_out("g15", 16'hF00F, 4'd15, 1'b1);

    // Fairness: 0 and 15 alternate, one word per cycle.
    fair_gnt[0] = 16'h0001; fair_word[0] = 16'hA5A5; fair_sel[0] = 4'd0;
    fair_gnt[1] = 16'h8000; fair_word[1] = 16'hF00F; fair_sel[1] = 4'd15;
    fair_gnt[2] = 16'h0001; fair_word[2] = 16'hA5A5; fair_sel[2] = 4'd0;
    fair_gnt[3] = 16'h8000; fair_word[3] = 16'hF00F; fair_sel[3] = 4'd15;
    req = 16'h8001;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("fair%0d.gnt", i), 32'(gnt), 32'(fair_gnt[i]));
      tick();
      chk_out($sformatf("fair%0d", i), fair_word[i], fair_sel[i], 1'b1);
    end

    // Grant 14 so ptr becomes 15, then wrap to requester 1.
    req = 16'h4000;
    setw(14, 16'hEEEE);
    #1;
    chk("g14.gnt", 32'(gnt), 32'h4000);
    tick();
    chk_out("g14", 16'hEEEE, 4'd14, 1'b1);
    req = 16'h0006;
    setw(2, 16'h1234);
    #1;
    chk("wrap.gnt", 32'(gnt), 32'h0002);
    tick();
    chk_out("wrap", 16'h1111, 4'd1, 1'b1);
    #1;
    chk("wrap2.gnt", 32'(gnt), 32'h0004);
    tick();
    chk_out("wrap2", 16'h1234, 4'd2, 1'b1);

    // Backpressure: hold for 5 cycles while din churns.
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = {16{16'(16'h0101 * (i + 1))}};
      #1;
      chk($sformatf("bp%0d.gnt", i), 32'(gnt), 32'h0);
      tick();
      chk_out($sformatf("bp%0d", i), 16'h1234, 4'd2, 1'b1);
    end

    // Release: completion and next grant (ptr=3 -> wraps to 1) together.
    din = '0;
    setw(1, 16'hBEEF);
    setw(2, 16'h2222);
    dout_ready = 1'b1;
    #1;
    chk("rel.gnt", 32'(gnt), 32'h0002);
    tick();
    chk_out("rel", 16'hBEEF, 4'd1, 1'b1);

    // Drain.
    req = 16'h0000;
    #1;
    chk("drain.gnt", 32'(gnt), 32'h0);
    tick();
    chk_out("drain", 16'hBEEF, 4'd1, 1'b0);

    // IDLE ignores dout_ready=0 and still grants (ptr=2 -> requester 4).
    dout_ready = 1'b0;
    req = 16'h0010;
    setw(4, 16'h4444);
    #1;
    chk("idle.gnt", 32'(gnt), 32'h0010);
    tick();
    chk_out("idle", 16'h4444, 4'd4, 1'b1);

    // Reset mid-transfer discards the held word and returns ptr to 0.
    req   = 16'h8001;
    setw(0, 16'h0A0A);
    reset = 1'b1;
    #1;
    chk("mrst.gnt", 32'(gnt), 32'h0);
    tick();
    chk_out("mrst", 16'h0000, 4'd0, 1'b0);
    reset = 1'b0;
    #1;
    chk("post.gnt", 32'(gnt), 32'h0001);
    tick();
    chk_out("post", 16'h0A0A, 4'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
